solver_controller: RTL and testbench
====================================

Name: solver_controller

Overview:
- Sequencer for a limb-serial Mandelbrot escape-time solver.
- Holds the run configuration: limb count and iteration limit.
- On start, steps the arithmetic datapath through every limb of every iteration, and samples the datapath's divergence flag once per iteration.
- Reports iteration count and completion to the host interface.

Parameters:
- LIMB_INDEX_BITS, 6, width of the limb index and of the limb-count register (max 2^LIMB_INDEX_BITS-1 limbs).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_num_limbs_en  in  1  load num_limbs_data into the limb-count register.
- num_limbs_data  in  LIMB_INDEX_BITS  limbs per operand.
- wr_iter_lim_en  in  1  load iter_lim_data into the iteration-limit register.
- iter_lim_data  in  16  maximum iterations.
- start  in  1  begin a run (level-sampled).
- diverged  in  1  datapath escape flag; valid in the CHECK cycle only.
- busy  out  1  high in RUN or CHECK.
- done  out  1  high in DONE until the next accepted start.
- escaped  out  1  result: run ended by divergence.
- iterations  out  16  completed-iteration count.
- limb_idx  out  LIMB_INDEX_BITS  current limb; LSB limb is 0.
- limb_valid  out  1  datapath processes limb_idx this cycle.
- first_limb  out  1  limb_valid and limb_idx==0.
- last_limb  out  1  limb_valid and limb_idx==num_limbs-1.
- first_iter  out  1  limb_valid during iteration 0 (datapath loads z=c).

Behaviour:
- Reset (async) sets:
  - state IDLE;
  - num_limbs=1, iter_lim=0;
  - busy, done, escaped, limb_valid, first_iter = 0;
  - iterations=0, limb_idx=0.
- Config writes:
  - Registered on the clock edge, accepted only in IDLE or DONE; ignored while busy.
  - Both enables in the same cycle load both registers.
  - num_limbs_data=0 is stored as 1.
- States: IDLE, RUN, CHECK, DONE.
- IDLE/DONE with start=1:
  - Clear iterations, escaped, done and limb_idx.
  - If iter_lim==0, go to DONE (iterations=0, escaped=0); otherwise go to RUN.
  - Start is ignored in RUN/CHECK.
  - Start held high in DONE restarts on the next edge.
- RUN:
  - limb_valid=1; limb_idx increments each cycle.
  - When limb_idx==num_limbs-1, go to CHECK next.
- CHECK:
  - limb_valid=0; iterations increments by 1.
  - If diverged, go to DONE with escaped=1.
  - Else if the new count equals iter_lim, go to DONE with escaped=0.
  - Otherwise go to RUN with limb_idx=0 and first_iter=0.
  - Divergence and limit reached together: escaped=1.
- diverged outside CHECK is ignored.
- Latency: start-accept edge to DONE entry = iter_lim*(num_limbs+1) cycles when no divergence.
- The iterations counter saturates at 16 bits; it cannot exceed iter_lim.
- Reset mid-run aborts immediately to the reset values.
- Outputs are registered, except first_limb and last_limb, which are decoded from registers.

Decomposition:
- Package solver_pkg holds:
  - state enum (IDLE, RUN, CHECK, DONE);
  - ITER_BITS=16;
  - reset constants NUM_LIMBS_RST=1, ITER_LIM_RST=0.
- One sub-module, limb_counter:
  - parameterised LIMB_INDEX_BITS;
  - inputs clear, enable, num_limbs;
  - outputs idx, first, last.
- The FSM and the iteration counter stay in solver_controller.

Test Plan:
- Reset, then num_limbs=5 and iter_lim=3 written together, start pulsed one cycle, diverged=0:
  - limb_idx sequences 0..4, then a CHECK cycle, three times;
  - done rises 18 cycles after the start edge; iterations=3, escaped=0;
  - first_iter is high only in the first pass.
- Same config, diverged=1 held in the second CHECK -> DONE with iterations=2, escaped=1, total 12 cycles.
- iter_lim=0, start -> DONE on the next edge; iterations=0, limb_valid never asserted.
- num_limbs_data=0 written, iter_lim=2 -> each pass is a single limb (first_limb and last_limb both high), done after 4 cycles.
- Config writes and start pulses during RUN are ignored:
  - the run completes with the original values;
  - num_limbs written as 3 after DONE takes effect on the next run.
- Async reset asserted mid-RUN -> all outputs return to reset values immediately; num_limbs reads back as 1.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared types and constants for the limb-serial Mandelbrot solver sequencer.
package solver_pkg;
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam int ITER_BITS     = 16;
    localparam int NUM_LIMBS_RST = 1;
    localparam int ITER_LIM_RST  = 0;
endpackage

// File: rtl/solver_controller_if.sv
// Host/datapath signal bundle for solver_controller: config, start, divergence in;
// status and limb stepping out.
interface solver_controller_if #(
    parameter int LIMB_INDEX_BITS = 6
);
    logic                            wr_num_limbs_en;
    logic [LIMB_INDEX_BITS-1:0]      num_limbs_data;
    logic                            wr_iter_lim_en;
    logic [solver_pkg::ITER_BITS-1:0] iter_lim_data;
    logic                            start;
    logic                            diverged;
    logic                            busy;
    logic                            done;
    logic                            escaped;
    logic [solver_pkg::ITER_BITS-1:0] iterations;
    logic [LIMB_INDEX_BITS-1:0]      limb_idx;
    logic                            limb_valid;
    logic                            first_limb;
    logic                            last_limb;
    logic                            first_iter;

    modport slave (
        input  wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
               start, diverged,
        output busy, done, escaped, iterations, limb_idx, limb_valid,
               first_limb, last_limb, first_iter
    );

    modport master (
        output wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data,
               start, diverged,
        input  busy, done, escaped, iterations, limb_idx, limb_valid,
               first_limb, last_limb, first_iter
    );
endinterface

// File: rtl/solver_controller_limb_counter.sv
// Limb index counter: clears to 0, steps by one when enabled, flags first/last limb.
module limb_counter #(
    parameter int LIMB_INDEX_BITS = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_clear,
    input  logic                       i_enable,
    input  logic [LIMB_INDEX_BITS-1:0] i_num_limbs,
    output logic [LIMB_INDEX_BITS-1:0] o_idx,
    output logic                       o_first,
    output logic                       o_last
);
    logic [LIMB_INDEX_BITS-1:0] r_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_idx <= '0;
        else if (i_clear)
            r_idx <= '0;
        else if (i_enable)
            r_idx <= r_idx + 1'b1;
    end

    // num_limbs is never 0, so num_limbs-1 cannot wrap
    assign o_idx   = r_idx;
    assign o_first = (r_idx == '0);
    assign o_last  = (r_idx == i_num_limbs - 1'b1);
endmodule

// File: rtl/solver_controller.sv
// Sequencer for the limb-serial escape-time solver: walks every limb of every
// iteration, samples divergence once per iteration and reports the result.
module solver_controller
    import solver_pkg::*;
#(
    parameter int LIMB_INDEX_BITS = 6
) (
    input  logic                clock,
    input  logic                reset,
    solver_controller_if.slave  bus
);
    state_t                     r_state;
    logic [LIMB_INDEX_BITS-1:0] r_num_limbs;
    logic [ITER_BITS-1:0]       r_iter_lim;
    logic [ITER_BITS-1:0]       r_iterations;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_escaped;
    logic                       r_limb_valid;
    logic                       r_first_iter;

    logic                       w_cfg_ok;
    logic                       w_accept;
    logic [ITER_BITS-1:0]       w_iter_next;
    logic                       w_stop;
    logic                       w_cnt_clear;
    logic                       w_cnt_en;
    logic [LIMB_INDEX_BITS-1:0] w_num_limbs_wr;
    logic [LIMB_INDEX_BITS-1:0] w_idx;
    logic                       w_first;
    logic                       w_last;

    assign w_cfg_ok       = (r_state == IDLE) || (r_state == DONE);
    assign w_accept       = w_cfg_ok && bus.start;
    assign w_iter_next    = (r_iterations == '1) ? r_iterations : r_iterations + 1'b1;
    assign w_stop         = bus.diverged || (w_iter_next == r_iter_lim);
    assign w_cnt_clear    = w_accept || ((r_state == CHECK) && !w_stop);
    assign w_cnt_en       = (r_state == RUN) && !w_last;
    // a zero limb count would make the last-limb compare wrap
    assign w_num_limbs_wr = (bus.num_limbs_data == '0) ? LIMB_INDEX_BITS'(1) : bus.num_limbs_data;

    limb_counter #(.LIMB_INDEX_BITS(LIMB_INDEX_BITS)) u_limb_counter (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_cnt_clear),
        .i_enable    (w_cnt_en),
        .i_num_limbs (r_num_limbs),
        .o_idx       (w_idx),
        .o_first     (w_first),
        .o_last      (w_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_num_limbs  <= LIMB_INDEX_BITS'(NUM_LIMBS_RST);
            r_iter_lim   <= ITER_BITS'(ITER_LIM_RST);
            r_iterations <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_escaped    <= 1'b0;
            r_limb_valid <= 1'b0;
            r_first_iter <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                if (bus.wr_num_limbs_en) r_num_limbs <= w_num_limbs_wr;
                if (bus.wr_iter_lim_en)  r_iter_lim  <= bus.iter_lim_data;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_iterations <= '0;
                        r_escaped    <= 1'b0;
                        if (r_iter_lim == '0) begin
                            r_state      <= DONE;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_limb_valid <= 1'b0;
                            r_first_iter <= 1'b0;
                        end else begin
                            r_state      <= RUN;
                            r_done       <= 1'b0;
                            r_busy       <= 1'b1;
                            r_limb_valid <= 1'b1;
                            r_first_iter <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state      <= CHECK;
                        r_limb_valid <= 1'b0;
                    end
                end
                CHECK: begin
                    r_iterations <= w_iter_next;
                    r_first_iter <= 1'b0;
                    if (w_stop) begin
                        // divergence wins over limit when both hit together
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_escaped <= bus.diverged;
                    end else begin
                        r_state      <= RUN;
                        r_limb_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.escaped    = r_escaped;
    assign bus.iterations = r_iterations;
    assign bus.limb_idx   = w_idx;
    assign bus.limb_valid = r_limb_valid;
    assign bus.first_iter = r_first_iter;
    assign bus.first_limb = r_limb_valid && w_first;
    assign bus.last_limb  = r_limb_valid && w_last;
endmodule

// File: tb/tb_solver_controller.sv
// Directed self-checking bench for solver_controller.
module tb_solver_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    solver_controller_if #(.LIMB_INDEX_BITS(6)) bus();

    solver_controller #(.LIMB_INDEX_BITS(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_cfg(input logic wn, input logic [5:0] n, input logic wi, input logic [15:0] l);
        bus.wr_num_limbs_en = wn;
        bus.num_limbs_data  = n;
        bus.wr_iter_lim_en  = wi;
        bus.iter_lim_data   = l;
        tick();
        bus.wr_num_limbs_en = 1'b0;
        bus.wr_iter_lim_en  = 1'b0;
    endtask

    // {limb_valid, limb_idx (only when valid), first_limb, last_limb, first_iter when valid, busy}
    function automatic logic [10:0] got_vec();
        return {bus.limb_valid, bus.limb_valid ? bus.limb_idx : 6'd0, bus.first_limb,
                bus.last_limb, bus.first_iter & bus.limb_valid, bus.busy};
    endfunction

    // Expected status c cycles after the start edge with n limbs per pass.
    function automatic logic [10:0] exp_vec(input int c, input int n);
        int p;
        int pass;
        logic [5:0] idx;
        p    = c % (n + 1);
        pass = c / (n + 1);
        idx  = 6'(p);
        if (p < n) return {1'b1, idx, p == 0, p == n - 1, pass == 0, 1'b1};
        return {1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.busy, bus.done, bus.escaped, bus.limb_valid, bus.first_iter, bus.iterations, bus.limb_idx} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b esc=%b lv=%b fi=%b it=%0d idx=%0d want all 0",
                     bus.busy, bus.done, bus.escaped, bus.limb_valid, bus.first_iter, bus.iterations, bus.limb_idx);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int c;
        write_cfg(1'b1, 6'd5, 1'b1, 16'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            checks++;
            if (got_vec() !== exp_vec(c, 5)) begin
                failures++;
                $display("FAIL normal_cycle%0d got=%h want=%h", c, got_vec(), exp_vec(c, 5));
            end
            tick();
            c++;
        end
        checks++;
        if (c !== 18) begin failures++; $display("FAIL normal_latency got=%0d want=18", c); end
        checks++;
        if ({bus.iterations, bus.escaped, bus.busy} !== {16'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL normal_result got it=%0d esc=%b busy=%b want it=3 esc=0 busy=0",
                     bus.iterations, bus.escaped, bus.busy);
        end
    endtask

    task automatic test_diverge();
        int c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            // pulse during RUN must be ignored; the one in the second CHECK counts
            bus.diverged = (c == 2) || (c == 11);
            checks++;
            if (got_vec() !== exp_vec(c, 5)) begin
                failures++;
                $display("FAIL diverge_cycle%0d got=%h want=%h", c, got_vec(), exp_vec(c, 5));
            end
            tick();
            c++;
        end
        bus.diverged = 1'b0;
        checks++;
        if (c !== 12) begin failures++; $display("FAIL diverge_latency got=%0d want=12", c); end
        checks++;
        if ({bus.iterations, bus.escaped} !== {16'd2, 1'b1}) begin
            failures++;
            $display("FAIL diverge_result got it=%0d esc=%b want it=2 esc=1", bus.iterations, bus.escaped);
        end
    endtask

    task automatic test_iter_zero();
        int lv_seen;
        write_cfg(1'b0, 6'd0, 1'b1, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.busy, bus.escaped, bus.iterations} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL iterzero_done got done=%b busy=%b esc=%b it=%0d want done=1 busy=0 esc=0 it=0",
                     bus.done, bus.busy, bus.escaped, bus.iterations);
        end
        lv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.limb_valid) lv_seen++;
            tick();
        end
        checks++;
        if (lv_seen !== 0) begin failures++; $display("FAIL iterzero_limb_valid got=%0d want=0", lv_seen); end
    endtask

    task automatic test_single_limb();
        int c;
        write_cfg(1'b1, 6'd0, 1'b1, 16'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            checks++;
            if (got_vec() !== exp_vec(c, 1)) begin
                failures++;
                $display("FAIL single_cycle%0d got=%h want=%h", c, got_vec(), exp_vec(c, 1));
            end
            tick();
            c++;
        end
        checks++;
        if ({c[7:0], bus.iterations} !== {8'd4, 16'd2}) begin
            failures++;
            $display("FAIL single_result got cycles=%0d it=%0d want cycles=4 it=2", c, bus.iterations);
        end
    endtask

    task automatic test_ignored_writes();
        int c;
        write_cfg(1'b1, 6'd2, 1'b1, 16'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            bus.wr_num_limbs_en = (c == 1);
            bus.wr_iter_lim_en  = (c == 1);
            bus.num_limbs_data  = 6'd3;
            bus.iter_lim_data   = 16'd7;
            bus.start           = (c == 2) || (c == 4);
            checks++;
            if (got_vec() !== exp_vec(c, 2)) begin
                failures++;
                $display("FAIL ignored_cycle%0d got=%h want=%h", c, got_vec(), exp_vec(c, 2));
            end
            tick();
            c++;
        end
        bus.wr_num_limbs_en = 1'b0;
        bus.wr_iter_lim_en  = 1'b0;
        bus.start           = 1'b0;
        checks++;
        if ({c[7:0], bus.iterations} !== {8'd6, 16'd2}) begin
            failures++;
            $display("FAIL ignored_result got cycles=%0d it=%0d want cycles=6 it=2", c, bus.iterations);
        end
        // now in DONE: num_limbs=3 applies, iter_lim stays 2
        write_cfg(1'b1, 6'd3, 1'b0, 16'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            checks++;
            if (got_vec() !== exp_vec(c, 3)) begin
                failures++;
                $display("FAIL newcfg_cycle%0d got=%h want=%h", c, got_vec(), exp_vec(c, 3));
            end
            tick();
            c++;
        end
        checks++;
        if ({c[7:0], bus.iterations} !== {8'd8, 16'd2}) begin
            failures++;
            $display("FAIL newcfg_result got cycles=%0d it=%0d want cycles=8 it=2", c, bus.iterations);
        end
    endtask

    task automatic test_back_to_back();
        write_cfg(1'b1, 6'd1, 1'b1, 16'd1);
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.iterations} !== {1'b1, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL b2b_first_done got done=%b busy=%b it=%0d want done=1 busy=0 it=1",
                     bus.done, bus.busy, bus.iterations);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.done, bus.busy, bus.limb_valid, bus.iterations} !== {1'b0, 1'b1, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL b2b_restart got done=%b busy=%b lv=%b it=%0d want done=0 busy=1 lv=1 it=0",
                     bus.done, bus.busy, bus.limb_valid, bus.iterations);
        end
        tick();
        tick();
        checks++;
        if ({bus.done, bus.iterations} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL b2b_second_done got done=%b it=%0d want done=1 it=1", bus.done, bus.iterations);
        end
    endtask

    task automatic test_async_reset();
        int c;
        write_cfg(1'b1, 6'd4, 1'b1, 16'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.escaped, bus.limb_valid, bus.first_iter, bus.iterations, bus.limb_idx} !== 27'd0) begin
            failures++;
            $display("FAIL async_reset got busy=%b done=%b esc=%b lv=%b fi=%b it=%0d idx=%0d want all 0",
                     bus.busy, bus.done, bus.escaped, bus.limb_valid, bus.first_iter, bus.iterations, bus.limb_idx);
        end
        tick();
        reset = 1'b0;
        tick();
        // num_limbs back at 1: one limb plus one check per pass
        write_cfg(1'b0, 6'd0, 1'b1, 16'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 0;
        while (!bus.done && c < 100) begin
            tick();
            c++;
        end
        checks++;
        if ({c[7:0], bus.iterations} !== {8'd2, 16'd1}) begin
            failures++;
            $display("FAIL post_reset_run got cycles=%0d it=%0d want cycles=2 it=1", c, bus.iterations);
        end
    endtask

    initial begin
        bus.wr_num_limbs_en = 1'b0;
        bus.num_limbs_data  = '0;
        bus.wr_iter_lim_en  = 1'b0;
        bus.iter_lim_data   = '0;
        bus.start           = 1'b0;
        bus.diverged        = 1'b0;
        test_reset();
        test_normal();
        test_diverge();
        test_iter_zero();
        test_single_limb();
        test_ignored_writes();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
